// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Opcodes, multiply FSM encoding and helpers for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_NOP  = 4'd12;

    localparam int MUL_STEPS = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_t;

    // Opcodes 0..8 produce a register result from the ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_ADDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iter_mul.sv
`default_nettype none
// ============================================================================
// Module      : iter_mul
// Description : Iterative shift-add multiplier, one partial product per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_mul
    import exec_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] product
);

    localparam int CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(MUL_STEPS - 1);

    mul_state_t       r_state;
    mul_state_t       w_state_next;
    logic [DW-1:0]    r_a_sh;
    logic [DW-1:0]    r_b_sh;
    logic [DW-1:0]    r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    w_acc_next;

    // The product includes the step taking place on the current edge, so the
    // consumer can register it on the same edge that finishes the multiply.
    assign w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : '0);
    assign busy       = (r_state == ST_BUSY);
    assign done       = busy && (r_cnt == C_LAST_STEP);
    assign product    = w_acc_next;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_BUSY;
            ST_BUSY: if (r_cnt == C_LAST_STEP) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_a_sh <= a;
                    r_b_sh <= b;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end
            end else begin
                r_acc  <= w_acc_next;
                r_a_sh <= r_a_sh << 1;
                r_b_sh <= r_b_sh >> 1;
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_stg.sv
`default_nettype none
// ============================================================================
// Module      : exec_stg
// Description : Execute stage: ALU, load/store address generation, iterative
//               multiply with upstream stall, registered outputs to MEM/WB.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stg
    import exec_pkg::*;
#(
    parameter int DW   = 16,
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [3:0]      opcode,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    input  logic [DW-1:0]   imm,
    input  logic [RA_W-1:0] rf_writea_in,
    output logic            stall_out,
    output logic [DW-1:0]   d_mem_wrap_addr,
    output logic [DW-1:0]   d_mem_wrap_wr_data,
    output logic            mem_modif,
    output logic            wr_rd_enable,
    output logic            write_bout,
    output logic [RA_W-1:0] rf_writea_out,
    output logic [DW-1:0]   alu_res,
    output logic            wb_sel_mem,
    output logic            flag_z,
    output logic            flag_c
);

    logic            w_mul_busy;
    logic            w_mul_done;
    logic [DW-1:0]   w_mul_prod;
    logic            w_accept;
    logic            w_mul_start;
    logic [DW-1:0]   w_alu_res;
    logic            w_alu_c;
    logic [DW-1:0]   w_ea;
    logic [RA_W-1:0] r_mul_rd;

    // Anything presented while the multiplier is busy is held upstream.
    assign w_accept    = in_valid && !w_mul_busy;
    assign w_mul_start = w_accept && (opcode == OP_MUL);
    assign stall_out   = w_mul_busy;
    assign w_ea        = op_a + imm;

    iter_mul #(
        .DW (DW)
    ) u_iter_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (opcode)
            OP_ADD:  {w_alu_c, w_alu_res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB: begin
                w_alu_res = op_a - op_b;
                w_alu_c   = (op_a >= op_b);
            end
            OP_AND:  w_alu_res = op_a & op_b;
            OP_OR:   w_alu_res = op_a | op_b;
            OP_XOR:  w_alu_res = op_a ^ op_b;
            OP_NOT:  w_alu_res = ~op_a;
            OP_SHL:  w_alu_res = op_a << op_b[3:0];
            OP_SHR:  w_alu_res = op_a >> op_b[3:0];
            OP_ADDI: {w_alu_c, w_alu_res} = {1'b0, op_a} + {1'b0, imm};
            default: w_alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_mem_wrap_addr    <= '0;
            d_mem_wrap_wr_data <= '0;
            mem_modif          <= 1'b0;
            wr_rd_enable       <= 1'b0;
            write_bout         <= 1'b0;
            rf_writea_out      <= '0;
            alu_res            <= '0;
            wb_sel_mem         <= 1'b0;
            flag_z             <= 1'b0;
            flag_c             <= 1'b0;
            r_mul_rd           <= '0;
        end else begin
            // Control strobes default to a bubble; data outputs hold.
            write_bout   <= 1'b0;
            mem_modif    <= 1'b0;
            wr_rd_enable <= 1'b0;
            if (w_mul_start) begin
                r_mul_rd <= rf_writea_in;
            end
            if (w_mul_done) begin
                alu_res         <= w_mul_prod;
                d_mem_wrap_addr <= w_mul_prod;
                write_bout      <= 1'b1;
                wb_sel_mem      <= 1'b0;
                rf_writea_out   <= r_mul_rd;
                flag_z          <= (w_mul_prod == '0);
                flag_c          <= 1'b0;
            end else if (w_accept) begin
                if (is_alu_op(opcode)) begin
                    alu_res         <= w_alu_res;
                    d_mem_wrap_addr <= w_alu_res;
                    write_bout      <= 1'b1;
                    wb_sel_mem      <= 1'b0;
                    rf_writea_out   <= rf_writea_in;
                    flag_z          <= (w_alu_res == '0);
                    flag_c          <= w_alu_c;
                end else if (opcode == OP_LW) begin
                    d_mem_wrap_addr <= w_ea;
                    mem_modif       <= 1'b1;
                    write_bout      <= 1'b1;
                    wb_sel_mem      <= 1'b1;
                    rf_writea_out   <= rf_writea_in;
                end else if (opcode == OP_SW) begin
                    d_mem_wrap_addr    <= w_ea;
                    d_mem_wrap_wr_data <= op_b;
                    mem_modif          <= 1'b1;
                    wr_rd_enable       <= 1'b1;
                    wb_sel_mem         <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/exec_stg.md
Name: exec_stg

Overview:
- Execute stage of the 6-stage 16-bit pipeline. Sits between register-read and memory-access.
- Performs ALU operations, address generation for loads and stores, and a multi-cycle iterative multiply that stalls upstream.
- Registers all control and data outputs consumed by the memory-access stage: address, write data, memory controls, register-file write enable and write address.
- Also registers the ALU result and a writeback-select bit for the writeback stage.

Parameters:
- DW, 16, datapath width.
- RA_W, 3, register-file address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present on the inputs.
- opcode  in  4  operation code.
- op_a  in  DW  source operand A.
- op_b  in  DW  source operand B; also store data.
- imm  in  DW  sign-extended immediate.
- rf_writea_in  in  RA_W  destination register.
- stall_out  out  1  upstream must hold its inputs.
- d_mem_wrap_addr  out  DW  memory address / ALU result.
- d_mem_wrap_wr_data  out  DW  store data.
- mem_modif  out  1  memory access this cycle.
- wr_rd_enable  out  1  1 = write, 0 = read.
- write_bout  out  1  register-file write enable.
- rf_writea_out  out  RA_W  destination register.
- alu_res  out  DW  result for writeback.
- wb_sel_mem  out  1  1 = writeback takes memory data.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.

Behaviour:
- Reset, asynchronous, active-low: every output register, the flags, the FSM state and the counter clear to 0. FSM goes to IDLE. stall_out = 0.
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~a.
  - 6 SHL: a<<b[3:0].
  - 7 SHR, logical: a>>b[3:0].
  - 8 ADDI: a+imm.
  - 9 LW.
  - 10 SW.
  - 11 MUL.
  - 12-15 NOP.
- Single-cycle ops, IDLE and in_valid: result is registered on the next edge; latency 1.
  - ALU ops (0-8): alu_res = d_mem_wrap_addr = result; write_bout = 1; mem_modif = 0; wb_sel_mem = 0.
  - LW: addr = a+imm (mod 2^16); mem_modif = 1; wr_rd_enable = 0; write_bout = 1; wb_sel_mem = 1.
  - SW: addr = a+imm; wr_data = b; mem_modif = 1; wr_rd_enable = 1; write_bout = 0.
  - NOP or !in_valid: bubble. write_bout = 0, mem_modif = 0, wr_rd_enable = 0; data outputs hold their previous values.
- Flags:
  - Updated only by valid ops 0-8 and MUL.
  - flag_z = (result == 0).
  - flag_c = carry-out for ADD/ADDI; no-borrow (a >= b) for SUB; 0 for all other ops.
  - Flags hold during bubbles, LW and SW.
- Multiply FSM, states IDLE and BUSY; stall_out = (state == BUSY), driven from state (not combinational on inputs).
  - IDLE, in_valid & MUL, at edge E0: latch a, b and rf_writea_in; clear the accumulator; cnt = 0; go to BUSY; emit a bubble.
  - BUSY: one shift-add step per edge: if b_sh[0], acc += a_sh; a_sh <<= 1; b_sh >>= 1; cnt++.
  - Edges E1..E15 emit bubbles.
  - At E16 (step with cnt == 15): outputs load the MUL result (low 16 bits of the product) with write_bout = 1 and wb_sel_mem = 0; flags update; go to IDLE.
  - The upstream instruction held during BUSY is accepted at E17.
  - MUL occupies 17 cycles; exactly one valid result is produced.
- Boundary cases:
  - Product overflow: truncated to low 16 bits; flag_c = 0.
  - MUL by 0: still takes 16 steps; result 0, flag_z = 1.
  - Shift amount 0: passes a unchanged. Only b[3:0] is used.
  - Back-to-back MULs: second starts at E17, no overlap.
  - Reset asserted mid-BUSY: multiply aborted, no result emitted, stall_out falls immediately (asynchronous).
  - in_valid while BUSY: ignored. Upstream is stalled and holds the instruction.

Decomposition:
- Package exec_pkg holds:
  - opcode localparams (OP_ADD .. OP_MUL, OP_NOP);
  - FSM state encoding (ST_IDLE, ST_BUSY);
  - MUL_STEPS = 16.
- Sub-module iter_mul: shift-add multiplier with start, busy, done and product ports, plus the step counter.
- exec_stg holds the combinational ALU, flag logic, output registers and stall generation.

Test Plan:
- Reset: reset = 0 mid-stream → all outputs 0, stall_out = 0. Release, then ADD 5+3 → next edge alu_res = 8, write_bout = 1, flag_z = 0, flag_c = 0.
- ADD 0xFFFF+0x0001 → alu_res = 0, flag_z = 1, flag_c = 1. Then SUB 3-5 → 0xFFFE, flag_c = 0.
- LW a = 0x0010, imm = 0xFFFE → addr 0x000E, mem_modif = 1, wr_rd_enable = 0, wb_sel_mem = 1. SW a = 4, imm = 2, b = 0xBEEF → addr 6, wr_data = 0xBEEF, wr_rd_enable = 1, write_bout = 0.
- MUL 300×7 followed by ADD 1+1 held by upstream:
  - stall_out high for 16 cycles;
  - alu_res = 0x0834 after E16 with exactly one write_bout pulse;
  - ADD result 2 after E17.
- MUL 0x1234×0x0100 → 0x3400 (truncated). MUL x×0 → 0, flag_z = 1. SHL 0x0001 by b = 0x0013 → 0x0008 (only b[3:0] used).
- Start MUL, assert reset at cycle 8 → stall_out drops immediately, no write_bout pulse. After release, ADD works with 1-cycle latency.
